// File: rtl/id_scoreboard.sv
// id_scoreboard: decode-stage issue controller.
// Tracks destination registers of in-flight long-latency ops and gates issue
// from ID into EX. It produces the stall/flush pair for the ID/EX register.
// CSR and fence-class ops are serialised: outstanding long ops drain first,
// then issue is held until the serial op retires.
//
// Optional feature macro: SB_WB_BYPASS_EN
//   Defined: a same-cycle writeback removes its register from the RAW/WAW
//            checks and frees one capacity slot, so issue can proceed in the
//            writeback cycle itself.
//   Undefined (default): the hazard checks use registered state only, so
//            issue resumes one cycle after the writeback.
module id_scoreboard #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             issue_valid_i,
  input  logic [4:0]       issue_rs1_i,
  input  logic [4:0]       issue_rs2_i,
  input  logic [4:0]       issue_rd_i,
  input  logic             issue_rf_en_i,
  input  logic             issue_long_i,
  input  logic             issue_serial_i,
  input  logic             ex_flush_i,
  input  logic             wb_valid_i,
  input  logic [4:0]       wb_rd_i,
  input  logic             serial_done_i,
  output logic             stall_o,
  output logic             flush_o,
  output logic [31:0]      pending_o,
  output logic [CNT_W-1:0] outstanding_o,
  output logic             err_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_EMPTY,
    ST_SERIAL
  } state_e;

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_OUTSTANDING);

  state_e           state_q, state_d;
  logic [31:0]      pending_q, pending_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic             err_q, err_d;

  logic             wb_has_rd;
  logic             wb_dec;
  logic [31:0]      wb_clr_mask;
  logic [31:0]      hz_pending;
  logic [CNT_W-1:0] hz_outstanding;
  logic             raw_hz, waw_hz, cap_hz, serial_hz;
  logic             serial_go;
  logic             stall;
  logic             accept;
  logic             set_pend;
  logic             err_pend;
  logic             err_cnt;

  // A writeback only frees a counter slot when something is outstanding.
  assign wb_has_rd = wb_valid_i & (wb_rd_i != 5'd0);
  assign wb_dec    = wb_valid_i & (outstanding_q != '0);
  assign err_cnt   = wb_valid_i & (outstanding_q == '0);

  // One-hot mask of the register being written back this cycle (x0 excluded).
  always_comb begin
    // NOTE: every variable written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    wb_clr_mask = '0;
    if (wb_has_rd) begin
      wb_clr_mask[wb_rd_i] = 1'b1;
    end
  end

`ifdef SB_WB_BYPASS_EN
  // Hazard view includes this cycle's writeback.
  assign hz_pending     = pending_q & ~wb_clr_mask;
  assign hz_outstanding = outstanding_q - CNT_W'(wb_dec);
`else
  // Hazard view is the registered state only.
  assign hz_pending     = pending_q;
  assign hz_outstanding = outstanding_q;
`endif

  // Hazard terms and the stall/accept decision.
  always_comb begin
    raw_hz    = ((issue_rs1_i != 5'd0) && hz_pending[issue_rs1_i]) ||
                ((issue_rs2_i != 5'd0) && hz_pending[issue_rs2_i]);
    waw_hz    = issue_rf_en_i && (issue_rd_i != 5'd0) && hz_pending[issue_rd_i];
    cap_hz    = issue_long_i && (hz_outstanding == MaxCnt);
    serial_hz = (state_q != ST_IDLE) || (issue_serial_i && (outstanding_q != '0));
    // The drain has finished and the serial op is still presented: this is
    // its accept cycle, so the serial hold is lifted for exactly this cycle.
    serial_go = (state_q == ST_WAIT_EMPTY) && (outstanding_q == '0) &&
                issue_valid_i && issue_serial_i && !ex_flush_i;
    stall     = issue_valid_i && !ex_flush_i && !serial_go &&
                (raw_hz || waw_hz || cap_hz || serial_hz);
    accept    = issue_valid_i && !stall && !ex_flush_i;
    set_pend  = accept && issue_long_i && issue_rf_en_i && (issue_rd_i != 5'd0);
  end

  // Serialisation FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (issue_valid_i && issue_serial_i && !ex_flush_i && (outstanding_q != '0)) begin
          state_d = ST_WAIT_EMPTY;
        end else if (accept && issue_serial_i) begin
          state_d = ST_SERIAL;
        end
      end
      ST_WAIT_EMPTY: begin
        // A redirect or a withdrawn serial op abandons the drain.
        if (ex_flush_i || !issue_valid_i || !issue_serial_i) begin
          state_d = ST_IDLE;
        end else if (serial_go) begin
          state_d = ST_SERIAL;
        end
      end
      ST_SERIAL: begin
        // The serial op is at or past EX, so redirects do not affect it.
        if (serial_done_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pending bitmap update: clear on writeback, set on accepted long op.
  always_comb begin
    pending_d = pending_q;
    err_pend  = 1'b0;
    if (wb_has_rd && !pending_q[wb_rd_i]) begin
      err_pend = 1'b1;
    end
    pending_d = pending_d & ~wb_clr_mask;
    // Applied after the clear so that a same-register set wins.
    if (set_pend) begin
      pending_d[issue_rd_i] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // Outstanding counter and sticky protocol error.
  always_comb begin
    outstanding_d = outstanding_q;
    if (accept && issue_long_i && !wb_dec) begin
      outstanding_d = outstanding_q + CNT_W'(1);
    end else if (!(accept && issue_long_i) && wb_dec) begin
      outstanding_d = outstanding_q - CNT_W'(1);
    end
    err_d = err_q | err_cnt | err_pend;
  end

  // State registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q       <= ST_IDLE;
      pending_q     <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q       <= state_d;
      pending_q     <= pending_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
    end
  end

  assign stall_o       = stall;
  assign flush_o       = ex_flush_i;
  assign pending_o     = pending_q;
  assign outstanding_o = outstanding_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_id_scoreboard.sv
// Directed, table-driven bench for id_scoreboard (MAX_OUTSTANDING=2).
// Inputs are applied just after a rising edge; outputs are compared on the
// following falling edge, so registered outputs show the pre-edge state.
module tb_id_scoreboard;

`ifdef SB_WB_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             arst_n = 1'b0;
  logic             issue_valid_i = 1'b0;
  logic [4:0]       issue_rs1_i = '0;
  logic [4:0]       issue_rs2_i = '0;
  logic [4:0]       issue_rd_i = '0;
  logic             issue_rf_en_i = 1'b0;
  logic             issue_long_i = 1'b0;
  logic             issue_serial_i = 1'b0;
  logic             ex_flush_i = 1'b0;
  logic             wb_valid_i = 1'b0;
  logic [4:0]       wb_rd_i = '0;
  logic             serial_done_i = 1'b0;
  logic             stall_o;
  logic             flush_o;
  logic [31:0]      pending_o;
  logic [CNT_W-1:0] outstanding_o;
  logic             err_o;

  id_scoreboard #(.MAX_OUTSTANDING(2)) dut (
    .clk           (clk),
    .arst_n        (arst_n),
    .issue_valid_i (issue_valid_i),
    .issue_rs1_i   (issue_rs1_i),
    .issue_rs2_i   (issue_rs2_i),
    .issue_rd_i    (issue_rd_i),
    .issue_rf_en_i (issue_rf_en_i),
    .issue_long_i  (issue_long_i),
    .issue_serial_i(issue_serial_i),
    .ex_flush_i    (ex_flush_i),
    .wb_valid_i    (wb_valid_i),
    .wb_rd_i       (wb_rd_i),
    .serial_done_i (serial_done_i),
    .stall_o       (stall_o),
    .flush_o       (flush_o),
    .pending_o     (pending_o),
    .outstanding_o (outstanding_o),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rf_en;
    logic        is_long;
    logic        serial;
    logic        flush;
    logic        wbv;
    logic [4:0]  wbr;
    logic        done;
    logic        e_stall;
    logic        e_flush;
    logic [31:0] e_pend;
    int          e_out;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_miss = 0;

  function automatic logic [31:0] b(input int n);
    logic [31:0] one;
    one = 32'd1;
    return one << n;
  endfunction

  function automatic vec_t mk(
    input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
    input logic [4:0] rd, input logic rf, input logic lng, input logic ser,
    input logic fl, input logic wbv, input logic [4:0] wbr, input logic dn,
    input logic es, input logic [31:0] ep, input int eo, input logic ee);
    vec_t t;
    t.valid = v;  t.rs1 = rs1;  t.rs2 = rs2;  t.rd = rd;  t.rf_en = rf;
    t.is_long = lng;  t.serial = ser;  t.flush = fl;  t.wbv = wbv;
    t.wbr = wbr;  t.done = dn;  t.e_stall = es;  t.e_flush = fl;
    t.e_pend = ep;  t.e_out = eo;  t.e_err = ee;
    return t;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    issue_valid_i  = t.valid;
    issue_rs1_i    = t.rs1;
    issue_rs2_i    = t.rs2;
    issue_rd_i     = t.rd;
    issue_rf_en_i  = t.rf_en;
    issue_long_i   = t.is_long;
    issue_serial_i = t.serial;
    ex_flush_i     = t.flush;
    wb_valid_i     = t.wbv;
    wb_rd_i        = t.wbr;
    serial_done_i  = t.done;
  endtask

  task automatic check_outs(input string tag, input vec_t t);
    check({tag, ".stall"}, {31'd0, stall_o}, {31'd0, t.e_stall});
    check({tag, ".flush"}, {31'd0, flush_o}, {31'd0, t.e_flush});
    check({tag, ".pending"}, pending_o, t.e_pend);
    check({tag, ".outstanding"}, {30'd0, outstanding_o}, 32'(t.e_out));
    check({tag, ".err"}, {31'd0, err_o}, {31'd0, t.e_err});
  endtask

  vec_t idle_v;

  initial begin
    idle_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0, 0, 0);

    //          v rs1 rs2 rd rf lg sr fl wbv wbr dn  stall pend          out err
    // load-use
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'd0,          0, 0));
    vecs.push_back(mk(1, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0,  0, 32'd0,          0, 0));
    vecs.push_back(mk(1, 5, 0, 6, 1, 0, 0, 0, 0, 0, 0,  1, b(5),           1, 0));
    vecs.push_back(mk(1, 5, 0, 6, 1, 0, 0, 0, 1, 5, 0, !Byp, b(5),         1, 0));
    vecs.push_back(mk(1, 5, 0, 6, 1, 0, 0, 0, 0, 0, 0,  0, 32'd0,          0, 0));
    // capacity
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0,  0, 32'd0,          0, 0));
    vecs.push_back(mk(1, 0, 0, 2, 1, 1, 0, 0, 0, 0, 0,  0, b(1),           1, 0));
    vecs.push_back(mk(1, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0,  1, b(1)|b(2),      2, 0));
    vecs.push_back(mk(1, 0, 0, 3, 1, 1, 0, 0, 1, 1, 0, !Byp, b(1)|b(2),    2, 0));
    vecs.push_back(mk(!Byp, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0,
                      Byp ? (b(2)|b(3)) : b(2), Byp ? 2 : 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, b(2)|b(3),      2, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0,  0, b(2)|b(3),      2, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0,  0, b(3),           1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'd0,          0, 0));
    // serial drain
    vecs.push_back(mk(1, 0, 0, 4, 1, 1, 0, 0, 0, 0, 0,  0, 32'd0,          0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,  1, b(4),           1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,  1, b(4),           1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 1, 4, 0,  1, b(4),           1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,  0, 32'd0,          0, 0));
    vecs.push_back(mk(1, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0,  1, 32'd0,          0, 0));
    vecs.push_back(mk(1, 0, 0, 9, 1, 0, 0, 0, 0, 0, 1,  1, 32'd0,          0, 0));
    vecs.push_back(mk(1, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0,  0, 32'd0,          0, 0));
    // flush
    vecs.push_back(mk(1, 0, 0, 7, 1, 1, 0, 1, 0, 0, 0,  0, 32'd0,          0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'd0,          0, 0));
    vecs.push_back(mk(1, 0, 0, 10, 1, 1, 0, 0, 0, 0, 0, 0, 32'd0,          0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,  1, b(10),          1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0,  0, b(10),          1, 0));
    vecs.push_back(mk(1, 0, 0, 9, 1, 0, 0, 0, 1, 10, 0, 0, b(10),          1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'd0,          0, 0));
    // serial accepted with serial_done in the same cycle still holds one cycle
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1,  0, 32'd0,          0, 0));
    vecs.push_back(mk(1, 0, 0, 9, 1, 0, 0, 0, 0, 0, 1,  1, 32'd0,          0, 0));
    vecs.push_back(mk(1, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0,  0, 32'd0,          0, 0));
    // x0 load and protocol errors
    vecs.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0,  0, 32'd0,          0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'd0,          1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  0, 32'd0,          1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'd0,          0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 12, 0, 0, 32'd0,          0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'd0,          0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'd0,          0, 1));
    // RAW on rs2, WAW, and a non-writing op to a pending rd
    vecs.push_back(mk(1, 0, 0, 11, 1, 1, 0, 0, 0, 0, 0, 0, 32'd0,          0, 1));
    vecs.push_back(mk(1, 0, 11, 12, 1, 0, 0, 0, 0, 0, 0, 1, b(11),         1, 1));
    vecs.push_back(mk(1, 0, 0, 11, 1, 0, 0, 0, 0, 0, 0, 1, b(11),          1, 1));
    vecs.push_back(mk(1, 0, 0, 11, 0, 0, 0, 0, 0, 0, 0, 0, b(11),          1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 11, 0, 0, b(11),          1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'd0,          0, 1));

    // Reset state, including flush_o following ex_flush_i during reset.
    drive(idle_v);
    ex_flush_i = 1'b1;
    #2;
    n_vec++;
    check("reset.flush", {31'd0, flush_o}, 32'd1);
    check("reset.stall", {31'd0, stall_o}, 32'd0);
    check("reset.pending", pending_o, 32'd0);
    check("reset.outstanding", {30'd0, outstanding_o}, 32'd0);
    check("reset.err", {31'd0, err_o}, 32'd0);
    ex_flush_i = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i]);
      @(negedge clk);
      n_vec++;
      check_outs($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset asserted in the middle of a load-use stall.
    @(posedge clk);
    #1;
    drive(mk(1, 0, 0, 13, 1, 1, 0, 0, 0, 0, 0, 0, 32'd0, 0, 0));
    @(posedge clk);
    #1;
    drive(mk(1, 13, 0, 14, 1, 0, 0, 0, 0, 0, 0, 0, 32'd0, 0, 0));
    @(negedge clk);
    n_vec++;
    check("rst_mid.stall_before", {31'd0, stall_o}, 32'd1);
    check("rst_mid.pending_before", pending_o, b(13));
    #1;
    arst_n = 1'b0;
    #1;
    n_vec++;
    check_outs("rst_mid", mk(1, 13, 0, 14, 1, 0, 0, 0, 0, 0, 0, 0, 32'd0, 0, 0));
    @(negedge clk);
    #1;
    arst_n = 1'b1;
    // The load launched before reset writes back: that is now a protocol error.
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 13, 0, 0, 32'd0, 0, 0));
    @(posedge clk);
    #1;
    drive(idle_v);
    @(negedge clk);
    n_vec++;
    check_outs("wb_after_rst", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0, 0, 1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/id_scoreboard.md
Name: id_scoreboard

Overview:
- Issue controller for the decode stage: tracks destination registers of in-flight long-latency ops (loads, CSR reads) and gates issue from ID into EX.
- Produces the decode stall/flush pair consumed by the ID/EX pipeline register.
- Serialises CSR/fence-class instructions by draining outstanding long ops first, then holding issue until the serial op retires.
- Short ALU ops are forwarded elsewhere and never tracked.

Parameters:
- MAX_OUTSTANDING, 2, maximum long ops in flight (1..7).
- CNT_W, $clog2(MAX_OUTSTANDING+1), outstanding counter width (derived; do not override).

Ports:
- clk  in  1  core clock
- arst_n  in  1  reset. One clock; asynchronous, active-low.
- issue_valid_i  in  1  ID holds a decoded instruction
- issue_rs1_i  in  5  source register 1
- issue_rs2_i  in  5  source register 2
- issue_rd_i  in  5  destination register
- issue_rf_en_i  in  1  instruction writes rd
- issue_long_i  in  1  long-latency op (load / CSR read)
- issue_serial_i  in  1  serialising op (CSR write, fence)
- ex_flush_i  in  1  redirect from EX (taken branch/jump)
- wb_valid_i  in  1  long-op writeback this cycle
- wb_rd_i  in  5  writeback destination
- serial_done_i  in  1  serial op retired
- stall_o  out  1  hold IF/ID, bubble into EX
- flush_o  out  1  kill ID/EX contents
- pending_o  out  32  pending bitmap; bit 0 always 0
- outstanding_o  out  CNT_W  long ops in flight
- err_o  out  1  sticky protocol error

Behaviour:
- Reset (arst_n=0, async): pending=0, outstanding=0, state=IDLE, err_o=0. Combinational outputs are stall_o=0 and flush_o=ex_flush_i.
- accept = issue_valid_i & ~stall_o & ~ex_flush_i.
- flush_o = ex_flush_i (combinational, same cycle).
- stall_o = issue_valid_i & ~ex_flush_i & any of:
  - RAW: rs1≠0 and pending[rs1]; rs2≠0 and pending[rs2].
  - WAW: issue_rf_en_i, rd≠0 and pending[rd].
  - Capacity: issue_long_i and outstanding==MAX_OUTSTANDING.
  - Serial ordering: state≠IDLE; or issue_serial_i and outstanding≠0.
- Set: accept & issue_long_i & issue_rf_en_i & rd≠0 sets pending[rd] at the next edge.
- Clear: wb_valid_i & wb_rd_i≠0 clears pending[wb_rd_i].
- Counter: +1 on accept&issue_long_i; −1 on wb_valid_i; both together → unchanged. The counter is tracked even for rd=0 loads.
- Protocol errors set err_o (cleared only by reset):
  - wb_valid_i with outstanding==0: counter holds at 0.
  - wb_valid_i with wb_rd_i≠0 and pending[wb_rd_i]=0: bit unchanged.
- FSM:
  - IDLE → WAIT_EMPTY: issue_valid_i & issue_serial_i & outstanding≠0 & ~ex_flush_i.
  - IDLE → SERIAL: accept & issue_serial_i.
  - WAIT_EMPTY → SERIAL: outstanding==0 & issue_valid_i & issue_serial_i & ~ex_flush_i. That cycle is the accept cycle; stall_o is forced 0 despite state≠IDLE.
  - WAIT_EMPTY → IDLE: ex_flush_i, or issue_valid_i dropped.
  - SERIAL → IDLE: serial_done_i. A serial op with serial_done_i in the same accept cycle still spends one cycle in SERIAL.
  - SERIAL ignores ex_flush_i, because the serial op is already at or past EX.
- ex_flush_i never clears pending bits or the counter. Tracked ops are always older than the redirecting instruction, since the same-cycle issue is blocked by accept.
- Reset mid-operation: all state returns to reset values immediately. In-flight writebacks after reset raise err_o.

Optional Feature:
- Macro SB_WB_BYPASS_EN.
- Defined: a same-cycle wb_valid_i/wb_rd_i removes that register from the RAW/WAW checks, and a same-cycle writeback frees one capacity slot. Issue can proceed in the writeback cycle.
  - If set and clear hit the same rd in one cycle, set wins: the bit stays 1.
- Undefined: hazard checks use registered pending/outstanding only, so issue resumes one cycle after writeback.

Test Plan:
- Load-use: issue load rd=5 (long), next cycle issue add rs1=5 → stall_o=1 until wb_rd_i=5. Issue occurs 1 cycle after wb (0 cycles with SB_WB_BYPASS_EN); pending_o[5] 1→0.
- Capacity: MAX_OUTSTANDING=2; issue loads rd=1, rd=2, then load rd=3 → third stalls, outstanding_o=2. wb rd=1 → third accepted, outstanding_o stays 2.
- Serial drain: one load outstanding, present CSR serial op → WAIT_EMPTY with stall_o=1. After wb: accepted, state SERIAL, following add stalls until serial_done_i, then issues next cycle.
- Flush: ex_flush_i=1 while load rd=7 presented → flush_o=1, stall_o=0, pending_o[7]=0, outstanding unchanged. Flush in WAIT_EMPTY → IDLE.
- x0/errors: load rd=0 → pending_o=0, outstanding_o=1. wb with outstanding_o=0 → err_o=1 and sticky. Assert arst_n low mid-stall → all outputs reset, stall_o=0.
